// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared seven-segment display constants and code table
package seven_seg_pkg;

    localparam int NIB_W = 4;
    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // Segment bit positions within a digit: {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low: every segment dark
    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_decode.sv
// rtl/seven_seg_decode.sv - combinational nibble to active-low segment code
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    input  logic             off_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_CODE[nibble_i];
        if (off_i) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seven_seg.sv
// rtl/seven_seg.sv - registered multi-digit hex seven-segment driver
module seven_seg
    import seven_seg_pkg::*;
#(
    parameter int DIGITS     = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   IN,
    input  logic [DIGITS-1:0]     OFF,
    output logic [7*DIGITS-1:0]   OUT
);

    // Blank pattern in the output polarity of this build
    localparam logic [7*DIGITS-1:0] DARK = ACTIVE_LOW ? {DIGITS{SEG_BLANK}}
                                                      : {DIGITS{~SEG_BLANK}};

    logic [7*DIGITS-1:0] code_al;
    logic [7*DIGITS-1:0] out_d;
    logic [7*DIGITS-1:0] out_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        seven_seg_decode u_decode (
            .nibble_i (IN[NIB_W*i +: NIB_W]),
            .off_i    (OFF[i]),
            .seg_o    (code_al[SEG_W*i +: SEG_W])
        );
    end

    always_comb begin
        out_d = ACTIVE_LOW ? code_al : ~code_al;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= DARK;
        end else begin
            out_q <= out_d;
        end
    end

    assign OUT = out_q;

endmodule

// File: tb/tb_seven_seg.sv
// tb/tb_seven_seg.sv - directed self-checking bench for seven_seg
module tb_seven_seg;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] in_v;
    logic [5:0]  off_v;
    logic [41:0] out_al;
    logic [41:0] out_ah;

    int checks   = 0;
    int failures = 0;

    logic [6:0] tbl [16];

    always #5 clk = ~clk;

    seven_seg #(.DIGITS(6), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk   (clk),
        .reset (reset),
        .IN    (in_v),
        .OFF   (off_v),
        .OUT   (out_al)
    );

    seven_seg #(.DIGITS(6), .ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk   (clk),
        .reset (reset),
        .IN    (in_v),
        .OFF   (off_v),
        .OUT   (out_ah)
    );

    task automatic check_eq(input string tag, input logic [41:0] got, input logic [41:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] rep6(input logic [6:0] b);
        return {6{b}};
    endfunction

    function automatic logic [41:0] pack6(input logic [6:0] d5, input logic [6:0] d4,
                                          input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = 7'h40; tbl[1]  = 7'h79; tbl[2]  = 7'h24; tbl[3]  = 7'h30;
        tbl[4]  = 7'h19; tbl[5]  = 7'h12; tbl[6]  = 7'h02; tbl[7]  = 7'h78;
        tbl[8]  = 7'h00; tbl[9]  = 7'h10; tbl[10] = 7'h08; tbl[11] = 7'h03;
        tbl[12] = 7'h46; tbl[13] = 7'h21; tbl[14] = 7'h06; tbl[15] = 7'h0E;

        // Reset held two edges with FEDEAD on the inputs
        reset = 1'b1;
        in_v  = 24'hFEDEAD;
        off_v = 6'b0;
        tick();
        tick();
        check_eq("reset_al", out_al, rep6(7'h7F));
        check_eq("reset_ah", out_ah, rep6(7'h00));
        reset = 1'b0;
        tick();
        check_eq("fedead_al", out_al, pack6(7'h0E, 7'h06, 7'h21, 7'h06, 7'h08, 7'h21));
        check_eq("fedead_ah", out_ah, ~pack6(7'h0E, 7'h06, 7'h21, 7'h06, 7'h08, 7'h21));

        // Sweep digit 0 through all nibbles
        in_v = 24'h000000;
        tick();
        for (int n = 0; n < 16; n++) begin
            in_v[3:0] = n[3:0];
            tick();
            check_eq($sformatf("sweep_%0h", n), out_al,
                     pack6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, tbl[n]));
        end

        // Single digit blanked
        in_v  = 24'h123456;
        off_v = 6'b000100;
        tick();
        check_eq("off_digit2", out_al, pack6(7'h79, 7'h24, 7'h30, 7'h7F, 7'h12, 7'h02));

        // One-edge latency: change lands just after edge N
        in_v  = 24'h000000;
        off_v = 6'b0;
        tick();
        check_eq("zero_al", out_al, rep6(7'h40));
        check_eq("zero_ah", out_ah, rep6(7'h3F));
        in_v = 24'h888888;
        #1;
        check_eq("latency_old", out_al, rep6(7'h40));
        tick();
        check_eq("latency_new", out_al, rep6(7'h00));

        // Glitch between edges must not reach OUT
        #2 in_v = 24'h111111;
        #2 in_v = 24'h888888;
        tick();
        check_eq("glitch", out_al, rep6(7'h00));

        // All digits off, both polarities
        in_v  = 24'h000000;
        off_v = 6'b111111;
        tick();
        check_eq("alloff_al", out_al, rep6(7'h7F));
        check_eq("alloff_ah", out_ah, rep6(7'h00));

        // IN and OFF change together; OFF wins
        in_v  = 24'hABCDEF;
        off_v = 6'b100001;
        tick();
        check_eq("simul_al", out_al, pack6(7'h7F, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F));
        check_eq("simul_ah", out_ah, ~pack6(7'h7F, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F));

        // Mid-operation single-edge reset
        in_v  = 24'h888888;
        off_v = 6'b0;
        tick();
        check_eq("pre_reset", out_al, rep6(7'h00));
        reset = 1'b1;
        tick();
        check_eq("mid_reset_al", out_al, rep6(7'h7F));
        check_eq("mid_reset_ah", out_ah, rep6(7'h00));
        reset = 1'b0;
        tick();
        check_eq("post_reset_al", out_al, rep6(7'h00));
        check_eq("post_reset_ah", out_ah, rep6(7'h7F));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg.md
SEVEN_SEG -- requirements
Module: seven_seg

Interface
REQ-001 Parameter DIGITS, default 6: number of hex digits driven.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 = segment lit when its output bit is 0 (board HEX displays).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port IN, input, 4*DIGITS bits: packed nibbles; digit i = IN[4i+3:4i], digit 0 least significant.
REQ-006 Port OFF, input, DIGITS bits: OFF[i]=1 blanks digit i.
REQ-007 Port OUT, output, 7*DIGITS bits: digit i segments = OUT[7i+6:7i], bit order {g,f,e,d,c,b,a} (bit 0 = a).

Function
REQ-008 OUT SHALL be registered; a change on IN/OFF appears on OUT exactly 1 clk edge later; no combinational path from inputs to OUT.
REQ-009 Each digit SHALL decode independently; digits do not interact.
REQ-010 With ACTIVE_LOW=1, digit codes SHALL be: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh.
REQ-011 With ACTIVE_LOW=0, each digit code SHALL be the bitwise inverse of REQ-010.
REQ-012 OFF[i]=1 SHALL drive digit i to all segments dark (7Fh active-low, 00h active-high), overriding IN regardless of its nibble value.
REQ-013 All 16 nibble values SHALL have a defined code; no default/X output for any input.
REQ-014 Simultaneous change of IN and OFF in the same cycle SHALL produce the OFF-resolved result on the next edge.
REQ-015 Inputs are sampled only at clk rising edge; glitches between edges SHALL not affect OUT.

Reset
REQ-016 While reset=1 at a rising edge, every digit of OUT SHALL become all-dark (7Fh per digit active-low), irrespective of IN/OFF.
REQ-017 Reset SHALL take priority over input capture; the first edge with reset=0 loads the decode of the current IN/OFF.
REQ-018 Reset asserted mid-operation SHALL blank all digits at the next edge; no other internal state exists.

Structure
REQ-019 Segment code constants (16 digit codes, blank code, segment bit order) SHALL live in the shared display package.
REQ-020 One combinational sub-module seven_seg_decode (4-bit nibble + off in, 7-bit code out, active-low) SHALL be instantiated DIGITS times by a generate loop; polarity inversion and output register reside in seven_seg.

Verification
REQ-021 Reset held 2 cycles with IN=FEDEADh, OFF=0 -> OUT every digit 7Fh; first edge after release -> digits 5..0 = 0Eh,06h,21h,06h,08h,21h.
REQ-022 Sweep digit 0 nibble 0..F, OFF=0 -> OUT[6:0] matches REQ-010 table one cycle after each change; other digits unchanged.
REQ-023 IN=123456h, OFF=000100b -> digit 2 = 7Fh, digits 5,4,3,1,0 = 79h,24h,30h,12h,02h.
REQ-024 Change IN from 000000h to 888888h at edge N -> OUT still all 40h immediately after edge N, all 00h after edge N+1.
REQ-025 ACTIVE_LOW=0 build, IN=000000h, OFF=0 -> each digit 3Fh; OFF all ones -> each digit 00h.
REQ-026 Assert reset for one edge while IN=888888h -> OUT all 7Fh for that cycle, returns to all 00h on the following edge.
